// File: rtl/uart_tx_if.sv
// Parallel request / serial line bundle between a UART_TX client and the transmitter.
// The client drives the word and configuration; the transmitter drives TX_OUT and busy.
interface uart_tx_if;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [4:0] Prescale;
  logic       TX_OUT;
  logic       busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    input  TX_OUT, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    output TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, stop; Prescale clk per bit.
// Optional macro UART_TX_TWO_STOP_EN stretches the stop phase to two bit periods.
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | line low for one bit period
// DATA   | shadow bits 0..7, one bit period each
// PARITY | XOR of data bits XOR PAR_TYP
// STOP   | line high for one (or two) bit periods
module uart_tx (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       par_en_q, par_en_d;
  logic       par_typ_q, par_typ_d;
  logic [4:0] pre_q, pre_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
`ifdef UART_TX_TWO_STOP_EN
  logic       stop2_q, stop2_d;
`endif

  logic       bit_done;
  logic [2:0] idx_nxt;
  logic       par_bit;

  assign bit_done = (cnt_q == (pre_q - 5'd1));
  assign idx_nxt  = idx_q + 3'd1;
  assign par_bit  = (^data_q) ^ par_typ_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      idx_q     <= 3'd0;
      data_q    <= 8'd0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      pre_q     <= 5'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      pre_q     <= pre_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_TWO_STOP_EN
      stop2_q   <= stop2_d;
`endif
    end
  end

  // Outputs are registered from the next-state decision, so the line and busy
  // change on the same edge as the state they belong to.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    pre_d     = pre_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
`ifdef UART_TX_TWO_STOP_EN
    stop2_d   = stop2_q;
`endif

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.Data_Valid) begin
          data_d    = bus.P_DATA;
          par_en_d  = bus.PAR_EN;
          par_typ_d = bus.PAR_TYP;
          pre_d     = (bus.Prescale == 5'd0) ? 5'd1 : bus.Prescale;
          cnt_d     = 5'd0;
          idx_d     = 3'd0;
          state_d   = START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end

      START: begin
        if (bit_done) begin
          cnt_d   = 5'd0;
          state_d = DATA;
          tx_d    = data_q[0];
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      DATA: begin
        if (bit_done) begin
          cnt_d = 5'd0;
          if (idx_q == 3'd7) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
`ifdef UART_TX_TWO_STOP_EN
            stop2_d = 1'b0;
`endif
          end else begin
            idx_d = idx_nxt;
            tx_d  = data_q[idx_nxt];
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      PARITY: begin
        if (bit_done) begin
          cnt_d   = 5'd0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          cnt_d = 5'd0;
`ifdef UART_TX_TWO_STOP_EN
          if (!stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            stop2_d = 1'b0;
            state_d = IDLE;
            busy_d  = 1'b0;
          end
`else
          state_d = IDLE;
          busy_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.TX_OUT = tx_q;
  assign bus.busy   = busy_q;

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter half of the UART: serialises one 8-bit parallel word per request into a standard asynchronous frame. The frame is a start bit, 8 data bits LSB first, an optional parity bit and a stop bit. It runs on the same system clock and Prescale/parity configuration inputs as the receiver, so a TX/RX pair can be looped back directly. An internal prescale counter sets the bit period, so no separate baud clock is needed.

## Interface
- No parameters; data width is fixed at 8 bits.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- P_DATA  input  8  parallel word to send; sampled only on an accepted request.
- Data_Valid  input  1  request strobe; accepted when high and busy is low.
- PAR_EN  input  1  1 = append a parity bit; sampled on accept.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on accept.
- Prescale  input  5  clk cycles per bit; sampled on accept; value 0 is treated as 1.
- TX_OUT  output  1  serial line, registered, idles high.
- busy  output  1  registered; high while a frame is in progress.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, busy=0.
  - When Data_Valid=1, latch P_DATA, PAR_EN, PAR_TYP and Prescale into shadow registers, then go to START.
- START: TX_OUT=0 for one bit period, then go to DATA.
- DATA:
  - Sends shadow bit 0 first, through bit 7, one bit period each.
  - A 3-bit index counts the bits; after bit 7, go to PARITY if PAR_EN was latched as 1, else go to STOP.
- PARITY:
  - Bit sent = XOR of the 8 latched data bits, XOR the latched PAR_TYP.
  - Even parity gives an even count of ones over data plus parity; odd parity gives an odd count.
- STOP: TX_OUT=1 for one bit period, then go to IDLE.
- Bit period:
  - A 5-bit counter counts 0 to Prescale-1 and clears on every bit boundary.
  - Each bit lasts exactly Prescale clk cycles.
- Input changes during a frame (P_DATA, PAR_EN, PAR_TYP, Prescale) do not affect that frame; only the shadow copies are used.
- Data_Valid while busy=1 is ignored, not queued.
- Reset (asynchronous, any state):
  - Outputs go immediately to TX_OUT=1, busy=0.
  - FSM returns to IDLE; counters and shadow registers clear.
  - A frame cut off by reset is abandoned, never resumed.

## Timing
- Accept edge = the rising edge where Data_Valid=1 and busy=0 (state IDLE).
- From the clock edge after the accept edge: busy=1 and TX_OUT=0 (start bit).
- Frame length = (10 + PAR_EN) × Prescale cycles.
- busy falls and TX_OUT stays 1 on the edge that ends the stop bit.
- Back-to-back: Data_Valid high in the first cycle where busy=0 is accepted, and the next start bit begins one cycle later. Minimum idle gap between frames is 1 clk.
- Reset values: TX_OUT=1, busy=0.

## Configuration
- Macro: UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2 bit periods (2 × Prescale cycles); frame = (11 + PAR_EN) × Prescale cycles.
- Undefined: one stop bit, as described above.

## Test plan
- Reset and idle:
  - Stimulus: assert rst=0 mid-frame, 20 cycles after a start bit.
  - Response: TX_OUT=1 and busy=0 immediately, without waiting for a clock edge.
  - After release: the line stays idle until a new Data_Valid.
- Even parity, 8'hA5:
  - Stimulus: Prescale=8, PAR_EN=1, PAR_TYP=0, P_DATA=8'hA5.
  - Response: line sequence 0, 1,0,1,0,0,1,0,1, parity 0, stop 1; each bit 8 cycles; busy high for 88 cycles.
- Odd parity, 8'h01:
  - Stimulus: Prescale=16, PAR_EN=1, PAR_TYP=1, P_DATA=8'h01.
  - Response: parity bit 0; frame lasts 176 cycles.
- No parity, 8'hFF:
  - Stimulus: Prescale=4, PAR_EN=0, P_DATA=8'hFF.
  - Response: start bit, eight 1s, stop bit; busy high for 40 cycles.
- Busy protection:
  - Stimulus: pulse Data_Valid with 8'h3C mid-frame, and change Prescale mid-frame.
  - Response: current frame is unchanged and 8'h3C is never sent.
- Back-to-back:
  - Stimulus: hold Data_Valid=1 with 8'h55 then 8'hAA, Prescale=8, no parity.
  - Response: second start bit begins exactly 1 cycle after busy falls; both frames decode correctly in a UART_RX loopback.
